// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_pkg : arbiter state encoding and read-return requester ids   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'b01,
    DMA_BURST = 2'b10
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_starve_counter : saturating count of CPU wins over a waiting DMA     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : CPU-priority arbiter for a single-port synchronous memory  |
// | with DMA starvation bound and bounded locked DMA bursts. Rev 1.0         |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_t    state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          force_cpu, force_nxt;
  logic          starve_max;
  logic          rd_valid;
  logic          rd_owner;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .CLK    (CLK),
    .reset  (reset),
    .inc    (cpu_gnt & dma_req),
    .clr    (dma_gnt | ~dma_req),
    .at_max (starve_max)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      burst_cnt <= '0;
      force_cpu <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      force_cpu <= force_nxt;
    end
  end

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    state_nxt = state;
    burst_nxt = burst_cnt;
    force_nxt = force_cpu;
    case (state)
      ARB: begin
        force_nxt = 1'b0;
        if (cpu_req && (force_cpu || !(dma_req && starve_max))) begin
          cpu_gnt = 1'b1;
        end else if (dma_req) begin
          dma_gnt = 1'b1;
          if (dma_lock) begin
            state_nxt = DMA_BURST;
            burst_nxt = BW'(1);
          end
        end
      end
      DMA_BURST: begin
        if (dma_req) begin
          dma_gnt   = 1'b1;
          burst_nxt = burst_cnt + BW'(1);
          // The beat that reaches BURST_MAX ends the burst and owes the CPU a slot.
          if (burst_cnt == BURST_LAST) begin
            state_nxt = ARB;
            force_nxt = 1'b1;
          end else if (!dma_lock) begin
            state_nxt = ARB;
          end
        end else begin
          state_nxt = ARB;
        end
      end
      default: begin
        state_nxt = ARB;
        burst_nxt = '0;
        force_nxt = 1'b0;
      end
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dma_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_owner <= OWNER_CPU;
    end else begin
      rd_valid <= (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
      rd_owner <= dma_gnt ? OWNER_DMA : OWNER_CPU;
    end
  end

  assign cpu_rvalid = rd_valid & (rd_owner == OWNER_CPU);
  assign dma_rvalid = rd_valid & (rd_owner == OWNER_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random checks of mem_arbiter against a     |
// | transaction-level arbitration model with a shadow memory. Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 8;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;

  bit [15:0] mem    [0:1023];
  bit [15:0] shadow [0:1023];

  int   total = 0;
  int   bad   = 0;
  int   m_starve, m_blen;
  bit   m_burst, m_force, m_cg, m_dg;
  bit   exp_rv;
  logic exp_owner;
  logic [15:0] exp_rd;
  logic obs_cg, obs_dg, obs_stall, obs_crv, obs_drv;
  logic [15:0] obs_crd, obs_drd;

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
  ) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Single-port synchronous memory; 1K words, address aliased on the low bits.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_blen = 0; m_burst = 0; m_force = 0; exp_rv = 0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check read return.
  task automatic step();
    bit cg, dg, we;
    logic [15:0] a, w;
    #1;
    cg = 0; dg = 0;
    if (!reset) begin
      if (m_burst) dg = dma_req;
      else if (cpu_req && (m_force || !(dma_req && m_starve >= STARVE_MAX))) cg = 1;
      else if (dma_req) dg = 1;
    end
    we = cg ? cpu_we : (dg ? dma_we : 1'b0);
    a  = cg ? cpu_addr : (dg ? dma_addr : 16'h0);
    w  = cg ? cpu_wdata : (dg ? dma_wdata : 16'h0);
    chk("cpu_gnt", cpu_gnt, cg);
    chk("dma_gnt", dma_gnt, dg);
    chk("cpu_stall", cpu_stall, cpu_req && !cg);
    chk("mem_en", mem_en, cg || dg);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, w);
    obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_stall = cpu_stall;
    @(posedge CLK);
    if (reset) model_reset();
    else begin
      exp_rv    = (cg || dg) && !we;
      exp_owner = cg ? OWNER_CPU : OWNER_DMA;
      exp_rd    = shadow[a[9:0]];
      if ((cg || dg) && we) shadow[a[9:0]] = w;
      if (dg || !dma_req) m_starve = 0;
      else if (cg && m_starve < STARVE_MAX) m_starve++;
      if (!m_burst) begin
        m_force = 0;
        if (dg && dma_lock) begin m_burst = 1; m_blen = 1; end
      end else if (!dg) m_burst = 0;
      else begin
        m_blen++;
        if (m_blen == BURST_MAX) begin m_burst = 0; m_force = 1; end
        else if (!dma_lock) m_burst = 0;
      end
    end
    @(negedge CLK);
    chk("cpu_rvalid", cpu_rvalid, exp_rv && exp_owner == OWNER_CPU);
    chk("dma_rvalid", dma_rvalid, exp_rv && exp_owner == OWNER_DMA);
    if (exp_rv && exp_owner == OWNER_CPU) chk("cpu_rdata", cpu_rdata, exp_rd);
    if (exp_rv && exp_owner == OWNER_DMA) chk("dma_rdata", dma_rdata, exp_rd);
    obs_crv = cpu_rvalid; obs_drv = dma_rvalid; obs_crd = cpu_rdata; obs_drd = dma_rdata;
    m_cg = cg; m_dg = dg;
  endtask

  initial begin
    logic [17:0] seq_c, seq_d, seq_s;
    logic [11:0] lb_c, lb_d;
    int nd;
    bit cpu_done;

    model_reset();
    reset = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h1234;
    dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 16'h0040; dma_wdata = 16'h0;

    // Everything quiet while reset is held, even with both requesters active.
    @(negedge CLK); #1;
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_dma_gnt", dma_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
    @(negedge CLK);
    reset = 0; dma_req = 0;

    // Preload 0x0010 = 0x1234, then CPU-only read.
    step();
    chk("cpu_wr_first_gnt", obs_cg, 1'b1);
    cpu_we = 0;
    step();
    chk("cpu_rd_gnt", obs_cg, 1'b1);
    chk("cpu_rd_stall", obs_stall, 1'b0);
    chk("cpu_rd_rvalid", obs_crv, 1'b1);
    chk("cpu_rd_data", obs_crd, 16'h1234);
    chk("cpu_rd_dma_rvalid", obs_drv, 1'b0);

    // Continuous contention, rolling into a 3-beat locked write burst.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    nd = 0;
    for (int i = 0; i < 18; i++) begin
      if (nd < 2) begin
        dma_req = 1; dma_we = 1; dma_lock = 0;
        dma_addr = 16'h0300 + 16'(nd); dma_wdata = 16'h5500 + 16'(nd);
      end else if (nd < 5) begin
        dma_req = 1; dma_we = 1; dma_lock = (nd < 4);
        dma_addr = 16'h0100 + 16'(nd - 2); dma_wdata = 16'hA000 + 16'(nd - 2);
      end else begin
        dma_req = 0; dma_lock = 0;
      end
      step();
      seq_c[i] = obs_cg; seq_d[i] = obs_dg; seq_s[i] = obs_stall;
      if (m_dg) nd++;
    end
    chk("starve_cpu_seq", seq_c, 18'b10_0011_1101_1110_1111);
    chk("starve_dma_seq", seq_d, 18'b01_1100_0010_0001_0000);
    chk("starve_stall_seq", seq_s, 18'b01_1100_0010_0001_0000);

    // Read back the burst data.
    cpu_req = 0; dma_req = 0;
    step();
    for (int b = 0; b < 3; b++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100 + 16'(b);
      step();
      cpu_req = 0;
      chk("burst_readback", {obs_crv, obs_crd}, {1'b1, 16'hA000 + 16'(b)});
    end

    // Locked burst longer than BURST_MAX with one CPU access arriving mid-burst.
    nd = 0; cpu_done = 0;
    for (int i = 0; i < 12; i++) begin
      dma_req = 1; dma_we = 1; dma_lock = 1;
      dma_addr = 16'h0200 + 16'(nd); dma_wdata = 16'h7700 + 16'(nd);
      cpu_req = (i >= 1) && !cpu_done; cpu_we = 0; cpu_addr = 16'h0010;
      step();
      lb_c[i] = obs_cg; lb_d[i] = obs_dg;
      if (m_dg) nd++;
      if (m_cg) cpu_done = 1;
    end
    chk("long_burst_dma_seq", lb_d, 12'b1110_1111_1111);
    chk("long_burst_cpu_seq", lb_c, 12'b0001_0000_0000);
    dma_req = 0; cpu_req = 0; dma_lock = 0;
    step(); step();

    // DMA read then CPU read back to back.
    dma_req = 1; dma_we = 0; dma_addr = 16'h0101;
    step();
    chk("b2b_dma_rvalid", {obs_drv, obs_crv}, 2'b10);
    chk("b2b_dma_rdata", obs_drd, 16'hA001);
    dma_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0102;
    step();
    chk("b2b_cpu_rvalid", {obs_crv, obs_drv}, 2'b10);
    chk("b2b_cpu_rdata", obs_crd, 16'hA002);
    cpu_req = 0;
    step();

    // Reset right after a locked DMA read grant.
    dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'h0010;
    #1;
    chk("rst_mid_dma_gnt", dma_gnt, 1'b1);
    @(posedge CLK); #1;
    reset = 1;
    model_reset();
    @(negedge CLK);
    chk("rst_mid_dma_rvalid", dma_rvalid, 1'b0);
    chk("rst_mid_outputs", {cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid}, 5'b0);
    chk("rst_mid_mem_addr", mem_addr, 16'h0);
    dma_req = 0; dma_lock = 0;
    step();
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    step();
    chk("post_rst_cpu_gnt", obs_cg, 1'b1);
    cpu_req = 0;
    step();

    // Random traffic; requests held until the model says they were granted.
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req && $urandom_range(0, 2) != 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      end
      if (!dma_req && $urandom_range(0, 4) != 0) begin
        dma_req = 1; dma_we = 1'($urandom_range(0, 1));
        dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
      end
      dma_lock = ($urandom_range(0, 4) != 0);
      step();
      if (m_cg) cpu_req = 0;
      if (m_dg) dma_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
